// File: rtl/bam8_prod_acc.sv
// rtl/bam8_prod_acc.sv - accumulates BAM8 product beats into one term and hands it on over valid/ready
// Overflow handling: define BAM8_PROD_ACC_SAT_EN to clamp, leave undefined to wrap.
module bam8_prod_acc #(
  parameter int ACC_W = 24,
  parameter int LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod_data,
  input  logic             prod_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [7:0]       acc_cnt,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             beat;
  logic             close;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [7:0]       cnt_nxt;
  logic             ovf_nxt;

  assign beat = prod_valid && prod_ready;

  // A term opening in IDLE starts from zero rather than the stale result.
  always_comb begin
    base    = (state == IDLE) ? '0 : acc_data;
    sum     = {1'b0, base} + {{(ACC_W - 15){1'b0}}, prod_data};
    cnt_nxt = (state == IDLE) ? 8'd1 : acc_cnt + 8'd1;
    ovf_nxt = ((state == IDLE) ? 1'b0 : acc_ovf) | sum[ACC_W];
    close   = prod_last || (cnt_nxt == 8'(LEN));
`ifdef BAM8_PROD_ACC_SAT_EN
    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (beat) state_nxt = close ? HOLD : ACCUM;
      HOLD:        if (acc_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = (state != HOLD);
    acc_valid  = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_data <= '0;
      acc_cnt  <= 8'd0;
      acc_ovf  <= 1'b0;
    end else if (beat) begin
      acc_data <= acc_nxt;
      acc_cnt  <= cnt_nxt;
      acc_ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_bam8_prod_acc.sv
// tb/tb_bam8_prod_acc.sv - randomized bench for bam8_prod_acc against a per-term arithmetic model
module tb_bam8_prod_acc;

  localparam int W0 = 17, L0 = 4;
  localparam int W1 = 24, L1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pv[2], pl[2], ar[2];
  logic [15:0]   pd[2];
  logic          prdy[2], av[2], ovf[2];
  logic [7:0]    cnt[2];
  logic [W0-1:0] data0;
  logic [W1-1:0] data1;

  int n_tests = 0;
  int n_fail  = 0;

  bam8_prod_acc #(.ACC_W(W0), .LEN(L0)) u0 (
    .clk(clk), .rst_n(rst_n), .prod_valid(pv[0]), .prod_ready(prdy[0]), .prod_data(pd[0]),
    .prod_last(pl[0]), .acc_valid(av[0]), .acc_ready(ar[0]), .acc_data(data0),
    .acc_cnt(cnt[0]), .acc_ovf(ovf[0]));

  bam8_prod_acc #(.ACC_W(W1), .LEN(L1)) u1 (
    .clk(clk), .rst_n(rst_n), .prod_valid(pv[1]), .prod_ready(prdy[1]), .prod_data(pd[1]),
    .prod_last(pl[1]), .acc_valid(av[1]), .acc_ready(ar[1]), .acc_data(data1),
    .acc_cnt(cnt[1]), .acc_ovf(ovf[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int u);
    return (u == 0) ? 32'(data0) : 32'(data1);
  endfunction

  // Term result from plain arithmetic on the product list.
  task automatic model(input int u, input logic [15:0] p[$],
                       output longint acc, output int n, output bit of);
    longint mx;
    mx  = (longint'(1) << ((u == 0) ? W0 : W1)) - 1;
    acc = 0; n = 0; of = 0;
    foreach (p[i]) begin
      acc += longint'(p[i]);
      if (acc > mx) begin
        of = 1;
`ifdef BAM8_PROD_ACC_SAT_EN
        acc = mx;
`else
        acc = acc - (mx + 1);
`endif
      end
      n++;
    end
  endtask

  task automatic send_term(input int u, input logic [15:0] p[$], input bit last,
                           input int gap_pct, input int hold);
    longint e_acc;
    int     e_n;
    bit     e_of;
    model(u, p, e_acc, e_n, e_of);
    foreach (p[i]) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        pv[u] = 1'b0; pd[u] = 16'($urandom); pl[u] = 1'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      check("ready_in_term", 32'(prdy[u]), 32'd1);
      check("valid_in_term", 32'(av[u]), 32'd0);
      pv[u] = 1'b1; pd[u] = p[i]; pl[u] = last && (i == p.size() - 1);
      @(posedge clk);
    end
    @(negedge clk);
    pv[u] = 1'b0; pd[u] = 16'($urandom); pl[u] = 1'($urandom);
    check("latency_valid", 32'(av[u]), 32'd1);
    check("acc_data", dout(u), 32'(e_acc));
    check("acc_cnt", 32'(cnt[u]), 32'(e_n));
    check("acc_ovf", 32'(ovf[u]), 32'(e_of));
    for (int h = 0; h < hold; h++) begin
      ar[u] = 1'b0; pv[u] = 1'b1; pd[u] = 16'($urandom); pl[u] = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(av[u]), 32'd1);
      check("hold_ready", 32'(prdy[u]), 32'd0);
      check("hold_data", dout(u), 32'(e_acc));
      check("hold_cnt", 32'(cnt[u]), 32'(e_n));
      check("hold_ovf", 32'(ovf[u]), 32'(e_of));
    end
    ar[u] = 1'b1; pv[u] = 1'b1; pd[u] = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    ar[u] = 1'b0; pv[u] = 1'b0;
    check("post_delivery_valid", 32'(av[u]), 32'd0);
    check("post_delivery_ready", 32'(prdy[u]), 32'd1);
  endtask

  task automatic random_term(input int u);
    logic [15:0] q[$];
    int len, lmax;
    bit last;
    lmax = (u == 0) ? L0 : L1;
    len  = $urandom_range(3) == 0 ? lmax : $urandom_range(lmax, 1);
    for (int i = 0; i < len; i++)
      q.push_back($urandom_range(1) ? 16'($urandom) : {8'($urandom), 8'h00});
    last = (len < lmax) ? 1'b1 : 1'($urandom);
    send_term(u, q, last, 30, $urandom_range(3));
  endtask

  initial begin
    logic [15:0] q[$];
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      pv[u] = 1'b0; pl[u] = 1'b0; ar[u] = 1'b0; pd[u] = 16'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid0", 32'(av[0]), 32'd0);
    check("rst_data0", dout(0), 32'd0);
    check("rst_cnt0", 32'(cnt[0]), 32'd0);
    check("rst_ovf0", 32'(ovf[0]), 32'd0);
    check("rst_valid1", 32'(av[1]), 32'd0);
    check("rst_data1", dout(1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(prdy[0]), 32'd1);

    q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    send_term(0, q, 1'b0, 0, 0);
    check("len4_sum_const", dout(0), 32'h000A00);

    q = '{16'h1234, 16'h0001};
    send_term(0, q, 1'b1, 0, 0);
    check("early_last_const", dout(0), 32'h001235);

    q = '{16'h0500, 16'h0600, 16'h0700};
    send_term(0, q, 1'b1, 0, 5);

    q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send_term(0, q, 1'b0, 0, 1);
`ifdef BAM8_PROD_ACC_SAT_EN
    check("ovf_const_data", dout(0), 32'h1FFFF);
`else
    check("ovf_const_data", dout(0), 32'h1FFFC);
`endif
    check("ovf_const_flag", 32'(ovf[0]), 32'd1);

    q = '{16'h0001};
    send_term(0, q, 1'b1, 0, 0);
    check("ovf_cleared", 32'(ovf[0]), 32'd0);

    // Reset in the middle of a term discards it.
    @(negedge clk);
    pv[0] = 1'b1; pd[0] = 16'h1100; pl[0] = 1'b0;
    @(negedge clk);
    pd[0] = 16'h2200;
    @(negedge clk);
    pv[0] = 1'b0; rst_n = 1'b0;
    check("pre_rst_valid", 32'(av[0]), 32'd0);
    check("pre_rst_cnt", 32'(cnt[0]), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 32'(av[0]), 32'd0);
    check("midrst_data", dout(0), 32'd0);
    check("midrst_cnt", 32'(cnt[0]), 32'd0);
    check("midrst_ready", 32'(prdy[0]), 32'd1);
    q = '{16'h0010, 16'h0020};
    send_term(0, q, 1'b1, 0, 0);
    check("after_rst_const", dout(0), 32'h30);

    for (int t = 0; t < 25; t++) random_term(0);

    for (int t = 0; t < 4; t++) begin
      q.delete();
      for (int i = 0; i < L1; i++) q.push_back(16'($urandom));
      send_term(1, q, 1'b0, 40, 2);
      check("len16_cnt", 32'(cnt[1]), 32'd16);
    end
    for (int t = 0; t < 12; t++) random_term(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
